// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes
// and datapath select codes.
package cpu_defs;

  localparam logic [3:0] StReset    = 4'd0;
  localparam logic [3:0] StFetch    = 4'd1;
  localparam logic [3:0] StDecode   = 4'd2;
  localparam logic [3:0] StMemAddr  = 4'd3;
  localparam logic [3:0] StMemRead  = 4'd4;
  localparam logic [3:0] StMemWb    = 4'd5;
  localparam logic [3:0] StMemWrite = 4'd6;
  localparam logic [3:0] StRExec    = 4'd7;
  localparam logic [3:0] StRWb      = 4'd8;
  localparam logic [3:0] StBranch   = 4'd9;
  localparam logic [3:0] StJump     = 4'd10;
  localparam logic [3:0] StIExec    = 4'd11;
  localparam logic [3:0] StIWb      = 4'd12;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluFunct = 4'b0010;

  localparam logic [1:0] SrcBRt     = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/instr_counter.sv
// Retired-instruction counter; synchronous active-low clear, wraps naturally.
module instr_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clr) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS datapath: walks each instruction through
// fetch/decode/execute/memory/write-back, stalling on mem_ready, and counts retirements.
module multicycle_control
  import cpu_defs::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [5:0]       op,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dest,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  logic [3:0] state_q, state_d;

  always_ff @(posedge clk) begin
    if (!clr) state_q <= StReset;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    pc_src     = PcSrcAlu;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dest   = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBRt;
    alu_ctrl   = AluAdd;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SrcBFour;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Branch target is computed speculatively here for BRANCH to use from ALUOut.
        alu_src_b = SrcBImmSh2;
        case (op)
          OpLw, OpSw: state_d = StMemAddr;
          OpRtype:    state_d = StRExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StIExec;
          OpJ:        state_d = StJump;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        state_d   = (op == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_ctrl  = AluFunct;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dest  = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_ctrl  = AluSub;
        pc_src    = PcSrcAluOut;
        pc_en     = alu_zero;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_src  = PcSrcJump;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StIExec: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        state_d   = StIWb;
      end
      StIWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StReset;
    endcase
  end

  instr_counter #(
    .CNT_W (CNT_W)
  ) u_instr_counter (
    .clk   (clk),
    .clr   (clr),
    .inc   (retire),
    .count (instr_count)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; outputs are packed into one
// vector and compared per cycle against hand-derived constants.
module tb_multicycle_control;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic [5:0]    op = 6'd0;
  logic          alu_zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_en, iord, mem_read, mem_write, ir_write, reg_dest, mem_to_reg;
  logic          reg_write, alu_src_a, retire, illegal;
  logic [1:0]    pc_src, alu_src_b;
  logic [3:0]    alu_ctrl;
  logic [CW-1:0] instr_count;
  logic [18:0]   ob;
  logic [CW-1:0] exp_cnt = '0;
  int            checks = 0;
  int            errors = 0;

  // {pc_en, pc_src, iord mem_read mem_write ir_write, reg_dest mem_to_reg reg_write,
  //  alu_src_a, alu_src_b, alu_ctrl, retire illegal}
  assign ob = {pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dest, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_ctrl, retire, illegal};

  localparam logic [18:0] F1   = 19'b1_00_0101_000_0_01_0000_00;
  localparam logic [18:0] F0   = 19'b0_00_0100_000_0_01_0000_00;
  localparam logic [18:0] DEC  = 19'b0_00_0000_000_0_11_0000_00;
  localparam logic [18:0] DECI = 19'b0_00_0000_000_0_11_0000_01;
  localparam logic [18:0] REX  = 19'b0_00_0000_000_1_00_0010_00;
  localparam logic [18:0] RWB  = 19'b0_00_0000_101_0_00_0000_10;
  localparam logic [18:0] MAD  = 19'b0_00_0000_000_1_10_0000_00;
  localparam logic [18:0] MRD  = 19'b0_00_1100_000_0_00_0000_00;
  localparam logic [18:0] MWB  = 19'b0_00_0000_011_0_00_0000_10;
  localparam logic [18:0] MW0  = 19'b0_00_1010_000_0_00_0000_00;
  localparam logic [18:0] MW1  = 19'b0_00_1010_000_0_00_0000_10;
  localparam logic [18:0] BR1  = 19'b1_01_0000_000_1_00_0001_10;
  localparam logic [18:0] BR0  = 19'b0_01_0000_000_1_00_0001_10;
  localparam logic [18:0] JMP  = 19'b1_10_0000_000_0_00_0000_10;
  localparam logic [18:0] IWB  = 19'b0_00_0000_001_0_00_0000_10;

  multicycle_control #(
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .op          (op),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dest    (reg_dest),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_ctrl    (alu_ctrl),
    .retire      (retire),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Holds clr low for several cycles, releases it and leaves the FSM stalled in FETCH.
  task automatic test_reset();
    @(negedge clk); clr = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (ob !== 19'd0) begin
        errors++; $display("FAIL reset_outputs cycle %0d: got %b want %b", i, ob, 19'd0);
      end
      checks++;
      if (instr_count !== '0) begin
        errors++; $display("FAIL reset_count cycle %0d: got %0d want 0", i, instr_count);
      end
    end
    @(negedge clk); clr = 1'b1; #1;
    checks++;
    if (ob !== 19'd0) begin
      errors++; $display("FAIL reset_release: got %b want %b", ob, 19'd0);
    end
    @(negedge clk); #1;
    checks++;
    if (ob !== F0) begin
      errors++; $display("FAIL reset_first_fetch: got %b want %b", ob, F0);
    end
    exp_cnt = '0;
  endtask

  // mem_ready low outside FETCH must not matter.
  task automatic test_rtype();
    logic [18:0] e [4];
    bit          r [4];
    e = '{F1, DEC, REX, RWB};
    r = '{1'b1, 1'b0, 1'b0, 1'b0};
    op = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = r[i]; #1;
      checks++;
      if (ob !== e[i]) begin
        errors++; $display("FAIL rtype cycle %0d: got %b want %b", i, ob, e[i]);
      end
    end
    @(posedge clk); #1; exp_cnt++;
    checks++;
    if (instr_count !== exp_cnt) begin
      errors++; $display("FAIL rtype_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_lw_stall();
    logic [18:0] e [8];
    bit          r [8];
    e = '{F1, DEC, MAD, MRD, MRD, MRD, MRD, MWB};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    op = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); mem_ready = r[i]; #1;
      checks++;
      if (ob !== e[i]) begin
        errors++; $display("FAIL lw_stall cycle %0d: got %b want %b", i, ob, e[i]);
      end
    end
    @(posedge clk); #1; exp_cnt++;
    checks++;
    if (instr_count !== exp_cnt) begin
      errors++; $display("FAIL lw_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  // Includes a one-cycle fetch stall and a one-cycle write stall.
  task automatic test_sw();
    logic [18:0] e [6];
    bit          r [6];
    e = '{F0, F1, DEC, MAD, MW0, MW1};
    r = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    op = 6'b101011;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); mem_ready = r[i]; #1;
      checks++;
      if (ob !== e[i]) begin
        errors++; $display("FAIL sw cycle %0d: got %b want %b", i, ob, e[i]);
      end
    end
    @(posedge clk); #1; exp_cnt++;
    checks++;
    if (instr_count !== exp_cnt) begin
      errors++; $display("FAIL sw_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_addi();
    logic [18:0] e [4];
    e = '{F1, DEC, MAD, IWB};
    op = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      checks++;
      if (ob !== e[i]) begin
        errors++; $display("FAIL addi cycle %0d: got %b want %b", i, ob, e[i]);
      end
    end
    @(posedge clk); #1; exp_cnt++;
    checks++;
    if (instr_count !== exp_cnt) begin
      errors++; $display("FAIL addi_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_beq(input bit z);
    logic [18:0] e [3];
    e = '{F1, DEC, (z ? BR1 : BR0)};
    op = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = 1'b1; alu_zero = (i == 2) ? z : ~z; #1;
      checks++;
      if (ob !== e[i]) begin
        errors++; $display("FAIL beq_z%0d cycle %0d: got %b want %b", z, i, ob, e[i]);
      end
    end
    @(posedge clk); #1; exp_cnt++;
    checks++;
    if (instr_count !== exp_cnt) begin
      errors++; $display("FAIL beq_z%0d_count: got %0d want %0d", z, instr_count, exp_cnt);
    end
  endtask

  task automatic test_jump();
    logic [18:0] e [3];
    e = '{F1, DEC, JMP};
    op = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      checks++;
      if (ob !== e[i]) begin
        errors++; $display("FAIL jump cycle %0d: got %b want %b", i, ob, e[i]);
      end
    end
    @(posedge clk); #1; exp_cnt++;
    checks++;
    if (instr_count !== exp_cnt) begin
      errors++; $display("FAIL jump_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  // Third cycle confirms the return to FETCH (held there by mem_ready=0).
  task automatic test_illegal();
    logic [18:0] e [3];
    bit          r [3];
    e = '{F1, DECI, F0};
    r = '{1'b1, 1'b1, 1'b0};
    op = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = r[i]; #1;
      checks++;
      if (ob !== e[i]) begin
        errors++; $display("FAIL illegal cycle %0d: got %b want %b", i, ob, e[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (instr_count !== exp_cnt) begin
      errors++; $display("FAIL illegal_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_count_wrap();
    logic [18:0] e [3];
    e = '{F1, DEC, JMP};
    op = 6'b000010;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); mem_ready = 1'b1; #1;
        checks++;
        if (ob !== e[i]) begin
          errors++; $display("FAIL wrap_j%0d cycle %0d: got %b want %b", n, i, ob, e[i]);
        end
      end
      @(posedge clk); #1; exp_cnt++;
      checks++;
      if (instr_count !== exp_cnt) begin
        errors++; $display("FAIL wrap_count%0d: got %0d want %0d", n, instr_count, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_sw_stall();
    logic [18:0] e [5];
    bit          r [5];
    e = '{F1, DEC, MAD, MW0, MW0};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ready = r[i]; #1;
      checks++;
      if (ob !== e[i]) begin
        errors++; $display("FAIL sw_stall cycle %0d: got %b want %b", i, ob, e[i]);
      end
    end
    @(negedge clk); clr = 1'b0; mem_ready = 1'b0; #1;
    checks++;
    if (ob !== MW0) begin
      errors++; $display("FAIL sw_stall_pre_reset: got %b want %b", ob, MW0);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_write !== 1'b0) begin
      errors++; $display("FAIL sw_reset_mem_write: got %b want 0", mem_write);
    end
    checks++;
    if (ob !== 19'd0) begin
      errors++; $display("FAIL sw_reset_outputs: got %b want %b", ob, 19'd0);
    end
    checks++;
    if (instr_count !== '0) begin
      errors++; $display("FAIL sw_reset_count: got %0d want 0", instr_count);
    end
    clr = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (ob !== F0) begin
      errors++; $display("FAIL sw_reset_refetch: got %b want %b", ob, F0);
    end
    exp_cnt = '0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw();
    test_addi();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jump();
    test_illegal();
    test_reset();
    test_count_wrap();
    test_reset_sw_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle decode with a Moore state machine that walks each instruction through fetch, decode, execute, memory and write-back steps, so one ALU and one unified memory port are shared across cycles. It drives every datapath mux select, register and memory strobe, stalls on a memory-ready handshake, and counts retired instructions.

## Interface

**Parameters**
- `CNT_W`, default 32: width of the retired-instruction counter.

**Ports**
- `clk`, input, 1: clock, rising edge.
- `clr`, input, 1: reset. Synchronous, active-low.
- `op`, input, 6: instruction[31:26], sampled from the instruction register.
- `alu_zero`, input, 1: ALU zero flag.
- `mem_ready`, input, 1: memory has completed the current access this cycle.
- `pc_en`, output, 1: PC load enable.
- `pc_src`, output, 2: PC source. 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `iord`, output, 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read`, output, 1: memory read strobe.
- `mem_write`, output, 1: memory write strobe.
- `ir_write`, output, 1: instruction register load.
- `reg_dest`, output, 1: write-register select. 0 = rt, 1 = rd.
- `mem_to_reg`, output, 1: write-data select. 0 = ALUOut, 1 = MDR.
- `reg_write`, output, 1: register file write enable.
- `alu_src_a`, output, 1: ALU operand A. 0 = PC, 1 = rs data.
- `alu_src_b`, output, 2: ALU operand B. 00 = rt data, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_ctrl`, output, 4: 0000 = ADD, 0001 = SUB, 0010 = use funct.
- `retire`, output, 1: pulses in the final cycle of a completed instruction.
- `illegal`, output, 1: pulses when the opcode is unsupported.
- `instr_count`, output, CNT_W: count of retired instructions.

## Operation

- **Supported opcodes:** R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- **Default output value:** every output not listed for a state is 0.
- **States and outputs:**
  - RESET: all outputs 0. Next state is FETCH.
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD. `ir_write` and `pc_en` equal `mem_ready`. The state holds while mem_ready=0 and moves to DECODE when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=11, ADD (computes the branch target). Next state by opcode: lw/sw→MEM_ADDR, R→R_EXEC, beq→BRANCH, addi→I_EXEC, j→JUMP. Any other opcode asserts `illegal` and goes to FETCH.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next is MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ: mem_read=1, iord=1. Holds until mem_ready, then goes to MEM_WB.
  - MEM_WB: reg_write=1, reg_dest=0, mem_to_reg=1. Retires.
  - MEM_WRITE: mem_write=1, iord=1. Holds until mem_ready. Retires in the mem_ready cycle.
  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl=0010. Next is R_WB.
  - R_WB: reg_write=1, reg_dest=1. Retires.
  - BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_en=alu_zero. Retires.
  - JUMP: pc_src=10, pc_en=1. Retires.
  - I_EXEC: alu_src_a=1, alu_src_b=10, ADD. Next is I_WB.
  - I_WB: reg_write=1, reg_dest=0. Retires.
- **Retire rule:** `retire`=1 exactly in a cycle whose next state is FETCH because an instruction completed. An illegal exit is not a retire.
- **Instruction counter:** `instr_count` increments by 1 on the clock edge ending each retire cycle. It wraps modulo 2^CNT_W.

## Timing

- **Reset:** `clr`=0 at a rising edge puts the state in RESET and sets `instr_count` to 0. This overrides any state, including stalled memory states; an in-flight mem_write is simply dropped.
- **Output timing:** all outputs are combinational from the registered state, plus `mem_ready`, `alu_zero` and `op` where stated. There is no output latency beyond the state register.
- **Latency with mem_ready=1:**
  - beq and j: 3 cycles.
  - R-type, addi and sw: 4 cycles.
  - lw: 5 cycles.
  - illegal: 2 cycles.
- **Stalls:** each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Strobes and the address select stay stable for the whole stall.
- **mem_ready outside the memory states:** ignored.

## Structure

- **Shared package `cpu_defs`:**
  - state encodings (4-bit, RESET=0);
  - opcode constants;
  - `alu_ctrl` codes;
  - `alu_src_b` and `pc_src` codes.
- **Sub-module `instr_counter`:** CNT_W-bit, with `clk`, `clr` and `inc`. This is the only natural split.
- **Main FSM:** next-state and output decode stay in the main module.

## Test plan

- **Reset:** hold clr=0 for 2 cycles after running some instructions. Required: all outputs 0 and instr_count=0 during RESET; the first FETCH cycle after clr=1 shows mem_read=1, alu_src_b=01.
- **R-type:** op=000000, mem_ready=1. Required: FETCH→DECODE→R_EXEC→R_WB; cycle 3 alu_ctrl=0010; cycle 4 reg_write=1, reg_dest=1, retire=1; instr_count goes 0→1.
- **lw with stall:** op=100011, mem_ready=0 for 3 cycles in MEM_READ. Required: mem_read=1 and iord=1 for 4 consecutive cycles; 8 cycles total; the last cycle has reg_write=1, mem_to_reg=1.
- **beq:** op=000100, alu_zero=1, then again with alu_zero=0. Required: the BRANCH cycle has pc_src=01 with pc_en=1, then pc_en=0; both retire in 3 cycles.
- **Illegal opcode:** op=111111. Required: illegal=1 in DECODE, next state FETCH, retire=0, instr_count unchanged.
- **Reset during sw stall:** sw with mem_ready=0, clr=0 mid-stall. Required: mem_write=0 on the next cycle, state RESET, instr_count=0.
